// File: rtl/alu_decode_stage.sv
// RV32I decode into ALU control and writeback controls, held in a registered ID/EX slot with a
// valid/ready handshake. Define ALU_DECODE_SKID_EN to add a one-entry skid buffer (registered ready_o).
module alu_decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [DATA_WIDTH-1:0]    pc_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [CONTROL_WIDTH-1:0] ALUctrl_o,
    output logic                     ALUSrc_o,
    output logic [DATA_WIDTH-1:0]    ImmExt_o,
    output logic                     RegWrite_o,
    output logic                     MemWrite_o,
    output logic                     Branch_o,
    output logic                     BranchNe_o,
    output logic                     Jump_o,
    output logic [1:0]               ResultSrc_o,
    output logic [4:0]               rs1_o,
    output logic [4:0]               rs2_o,
    output logic [4:0]               rd_o,
    output logic [DATA_WIDTH-1:0]    pc_o,
    output logic                     illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD   = 3'b000;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB   = 3'b001;
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND   = 3'b010;
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR    = 3'b011;
    localparam logic [CONTROL_WIDTH-1:0] ALU_XOR   = 3'b100;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLL   = 3'b101;
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRL   = 3'b110;
    localparam logic [CONTROL_WIDTH-1:0] ALU_PASSB = 3'b111;

    typedef struct packed {
        logic [CONTROL_WIDTH-1:0] alu_ctrl;
        logic                     alu_src;
        logic [DATA_WIDTH-1:0]    imm_ext;
        logic                     reg_write;
        logic                     mem_write;
        logic                     branch;
        logic                     branch_ne;
        logic                     jump;
        logic [1:0]               result_src;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [DATA_WIDTH-1:0]    pc;
        logic                     illegal;
    } dec_t;

    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic                  funct7b5_s;
    logic [DATA_WIDTH-1:0] imm_i_s;
    logic [DATA_WIDTH-1:0] imm_s_s;
    logic [DATA_WIDTH-1:0] imm_b_s;
    logic [DATA_WIDTH-1:0] imm_u_s;
    logic [DATA_WIDTH-1:0] imm_j_s;
    logic                  ill_s;
    logic                  accept_s;
    dec_t                  dec_s;
    dec_t                  slot_r;
    logic                  valid_r;

    assign opcode_s   = instr_i[6:0];
    assign funct3_s   = instr_i[14:12];
    assign funct7b5_s = instr_i[30];

    assign imm_i_s = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s_s = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_s = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_s = {instr_i[31:12], 12'h000};
    assign imm_j_s = {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

    // Combinational decode of the instruction currently offered by fetch
    always_comb begin
        dec_s = '0;
        ill_s = 1'b0;
        case (opcode_s)
            OP_R, OP_IMM: begin
                dec_s.reg_write = 1'b1;
                if (opcode_s == OP_IMM) begin
                    dec_s.alu_src = 1'b1;
                    dec_s.imm_ext = imm_i_s;
                end else begin
                    dec_s.alu_src = 1'b0;
                    dec_s.imm_ext = '0;
                end
                case (funct3_s)
                    3'b000: begin
                        if ((opcode_s == OP_R) && funct7b5_s) begin
                            dec_s.alu_ctrl = ALU_SUB;
                        end else begin
                            dec_s.alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b100:  dec_s.alu_ctrl = ALU_XOR;
                    3'b110:  dec_s.alu_ctrl = ALU_OR;
                    3'b111:  dec_s.alu_ctrl = ALU_AND;
                    3'b001:  dec_s.alu_ctrl = ALU_SLL;
                    3'b101: begin
                        // arithmetic right shift has no ALU code
                        if (funct7b5_s) begin
                            ill_s = 1'b1;
                        end else begin
                            dec_s.alu_ctrl = ALU_SRL;
                        end
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_s.alu_ctrl   = ALU_ADD;
                dec_s.alu_src    = 1'b1;
                dec_s.imm_ext    = imm_i_s;
                dec_s.result_src = 2'b01;
                dec_s.reg_write  = 1'b1;
            end
            OP_STORE: begin
                dec_s.alu_ctrl  = ALU_ADD;
                dec_s.alu_src   = 1'b1;
                dec_s.imm_ext   = imm_s_s;
                dec_s.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_s.alu_ctrl  = ALU_SUB;
                dec_s.imm_ext   = imm_b_s;
                dec_s.branch    = 1'b1;
                dec_s.branch_ne = funct3_s[0];
                if (funct3_s[2:1] != 2'b00) begin
                    ill_s = 1'b1;
                end else begin
                    ill_s = 1'b0;
                end
            end
            OP_LUI: begin
                dec_s.alu_ctrl  = ALU_PASSB;
                dec_s.alu_src   = 1'b1;
                dec_s.imm_ext   = imm_u_s;
                dec_s.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec_s.imm_ext    = imm_j_s;
                dec_s.jump       = 1'b1;
                dec_s.result_src = 2'b10;
                dec_s.reg_write  = 1'b1;
            end
            OP_JALR: begin
                dec_s.alu_ctrl   = ALU_ADD;
                dec_s.alu_src    = 1'b1;
                dec_s.imm_ext    = imm_i_s;
                dec_s.jump       = 1'b1;
                dec_s.result_src = 2'b10;
                dec_s.reg_write  = 1'b1;
            end
            default: ill_s = 1'b1;
        endcase

        // Illegal entries still travel down the pipe but can have no side effects
        if (ill_s) begin
            dec_s.alu_ctrl   = ALU_ADD;
            dec_s.alu_src    = 1'b0;
            dec_s.reg_write  = 1'b0;
            dec_s.mem_write  = 1'b0;
            dec_s.branch     = 1'b0;
            dec_s.branch_ne  = 1'b0;
            dec_s.jump       = 1'b0;
            dec_s.result_src = 2'b00;
            dec_s.illegal    = 1'b1;
        end else begin
            dec_s.illegal    = 1'b0;
        end

        dec_s.rs1 = instr_i[19:15];
        dec_s.rs2 = instr_i[24:20];
        dec_s.pc  = pc_i;
        if (dec_s.reg_write) begin
            dec_s.rd = instr_i[11:7];
        end else begin
            dec_s.rd = 5'd0;
        end
    end

    assign accept_s = valid_i & ready_o & ~flush_i;

`ifdef ALU_DECODE_SKID_EN
    dec_t skid_r;
    logic skid_full_r;

    assign ready_o = ~skid_full_r;

    // Output slot plus skid: skid drains into the slot before new input is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r     <= 1'b0;
            slot_r      <= '0;
            skid_full_r <= 1'b0;
            skid_r      <= '0;
        end else if (flush_i) begin
            valid_r     <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (!valid_r || ready_i) begin
            if (skid_full_r) begin
                slot_r      <= skid_r;
                valid_r     <= 1'b1;
                skid_full_r <= 1'b0;
            end else if (accept_s) begin
                slot_r  <= dec_s;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r      <= dec_s;
            skid_full_r <= 1'b1;
        end
    end
`else
    assign ready_o = ~valid_r | ready_i;

    // Single output slot: reset > flush > reload on accept > drain on handoff
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            slot_r  <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            slot_r  <= dec_s;
            valid_r <= 1'b1;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end
    end
`endif

    assign valid_o     = valid_r;
    assign ALUctrl_o   = slot_r.alu_ctrl;
    assign ALUSrc_o    = slot_r.alu_src;
    assign ImmExt_o    = slot_r.imm_ext;
    assign RegWrite_o  = slot_r.reg_write;
    assign MemWrite_o  = slot_r.mem_write;
    assign Branch_o    = slot_r.branch;
    assign BranchNe_o  = slot_r.branch_ne;
    assign Jump_o      = slot_r.jump;
    assign ResultSrc_o = slot_r.result_src;
    assign rs1_o       = slot_r.rs1;
    assign rs2_o       = slot_r.rs2;
    assign rd_o        = slot_r.rd;
    assign pc_o        = slot_r.pc;
    assign illegal_o   = slot_r.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: the driver queues hand-computed decodes on accept,
// a monitor pops and compares on every output handshake. Build with ALU_DECODE_SKID_EN for skid mode.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [2:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic        rw;
        logic        mw;
        logic        br;
        logic        bne;
        logic        jmp;
        logic [1:0]  res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

`ifdef ALU_DECODE_SKID_EN
    localparam int EXP_ABSORB = 1;
`else
    localparam int EXP_ABSORB = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  ALUctrl_o;
    logic        ALUSrc_o;
    logic [31:0] ImmExt_o;
    logic        RegWrite_o, MemWrite_o, Branch_o, BranchNe_o, Jump_o;
    logic [1:0]  ResultSrc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] pc_o;
    logic        illegal_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t got_s;
    exp_t mon_exp;

    alu_decode_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
        .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .ALUctrl_o(ALUctrl_o), .ALUSrc_o(ALUSrc_o), .ImmExt_o(ImmExt_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
        .BranchNe_o(BranchNe_o), .Jump_o(Jump_o), .ResultSrc_o(ResultSrc_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    assign got_s = {ALUctrl_o, ALUSrc_o, ImmExt_o, RegWrite_o, MemWrite_o, Branch_o,
                    BranchNe_o, Jump_o, ResultSrc_o, rs1_o, rs2_o, rd_o, pc_o, illegal_o};

    function automatic exp_t mk(input logic [2:0] alu, input logic src, input logic [31:0] imm,
                                input logic [4:0] en, input logic [1:0] res,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] pc, input logic ill);
        exp_t e;
        e = {alu, src, imm, en, res, rs1, rs2, rd, pc, ill};
        return e;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_out(input string name, input exp_t req);
        checks++;
        if (got_s !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got_s, req);
        end
    endtask

    // Offer one instruction until accepted (bounded); queue its expected decode if asked
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                        input logic push);
        logic acc;
        acc     = 1'b0;
        instr_i = ins;
        pc_i    = pc;
        valid_i = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready_o=0 expected ready_o=1 instr %h", ins);
        end else if (push) begin
            sb_q.push_back(e);
        end else begin
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %h expected none", got_s);
            end else begin
                mon_exp = sb_q.pop_front();
                if (got_s !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard got %h expected %h", got_s, mon_exp);
                end
            end
        end
    end

    initial begin
        exp_t e_sub, e_xori, e_x;
        logic [31:0] st_ins [2];
        logic [31:0] st_pc  [2];
        exp_t        st_exp [2];
        int          idx;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        instr_i = 32'h0; pc_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_bit("reset_valid", valid_o, 1'b0);
        chk_out("reset_outputs", '0);
        chk_bit("reset_ready", ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        // Back-to-back sub / xori with ready_i high, then illegal and edge encodings
        ready_i = 1'b1;
        e_sub  = mk(3'b001, 1'b0, 32'h0, 5'b10000, 2'b00, 5'd1, 5'd2, 5'd0, 32'h100, 1'b0);
        e_xori = mk(3'b100, 1'b1, 32'hA, 5'b10000, 2'b00, 5'd2, 5'd10, 5'd1, 32'h104, 1'b0);
        send(32'h40208033, 32'h100, e_sub, 1'b1);
        chk_out("sub_latency", e_sub);
        send(32'h00A14093, 32'h104, e_xori, 1'b1);
        chk_out("xori_latency", e_xori);
        send(32'h40205033, 32'h108,
             mk(3'b000, 1'b0, 32'h0, 5'b00000, 2'b00, 5'd0, 5'd2, 5'd0, 32'h108, 1'b1), 1'b1);
        send(32'h00000000, 32'h10C,
             mk(3'b000, 1'b0, 32'h0, 5'b00000, 2'b00, 5'd0, 5'd0, 5'd0, 32'h10C, 1'b1), 1'b1);
        send(32'hFE209EE3, 32'h110,
             mk(3'b001, 1'b0, 32'hFFFFFFFC, 5'b00110, 2'b00, 5'd1, 5'd2, 5'd0, 32'h110, 1'b0), 1'b1);
        send(32'h123450B7, 32'h114,
             mk(3'b111, 1'b1, 32'h12345000, 5'b10000, 2'b00, 5'd8, 5'd3, 5'd1, 32'h114, 1'b0), 1'b1);
        send(32'h010000EF, 32'h118,
             mk(3'b000, 1'b0, 32'h10, 5'b10001, 2'b10, 5'd0, 5'd16, 5'd1, 32'h118, 1'b0), 1'b1);
        idle(3);

        // Stall: sw held in the slot for 3 cycles while lw then xori are offered
        ready_i = 1'b0;
        e_x = mk(3'b000, 1'b1, 32'h8, 5'b01000, 2'b00, 5'd2, 5'd5, 5'd0, 32'h200, 1'b0);
        send(32'h00512423, 32'h200, e_x, 1'b1);
        st_ins[0] = 32'h00412183; st_pc[0] = 32'h204;
        st_exp[0] = mk(3'b000, 1'b1, 32'h4, 5'b10000, 2'b01, 5'd2, 5'd4, 5'd3, 32'h204, 1'b0);
        st_ins[1] = 32'h00A14093; st_pc[1] = 32'h208;
        st_exp[1] = mk(3'b100, 1'b1, 32'hA, 5'b10000, 2'b00, 5'd2, 5'd10, 5'd1, 32'h208, 1'b0);
        idx = 0;
        instr_i = st_ins[0]; pc_i = st_pc[0]; valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk_out("stall_frozen", e_x);
            chk_bit("stall_valid", valid_o, 1'b1);
            chk_bit("stall_ready", ready_o, idx < EXP_ABSORB);
            if (ready_o && idx < 2) begin
                sb_q.push_back(st_exp[idx]);
                idx++;
            end
            @(posedge clk_i);
            #1;
            if (idx < 2) begin
                instr_i = st_ins[idx];
                pc_i    = st_pc[idx];
            end
        end
        chk_int("stall_absorbed", idx, EXP_ABSORB);
        ready_i = 1'b1;
        for (int i = idx; i < 2; i++) send(st_ins[i], st_pc[i], st_exp[i], 1'b1);
        idle(3);

        // Flush with a held entry and a new offer: both disappear
        ready_i = 1'b0;
        send(32'h40208033, 32'h300, e_sub, 1'b0);
        instr_i = 32'h00A14093; pc_i = 32'h304; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_bit("flush_kill", valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        idle(3);
        chk_bit("flush_drop", valid_o, 1'b0);

        // Reset in the middle of a stall with an instruction on offer
        ready_i = 1'b0;
        send(32'h123450B7, 32'h400, e_sub, 1'b0);
        instr_i = 32'h00412183; pc_i = 32'h404; valid_i = 1'b1; rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_bit("rst_stall_valid", valid_o, 1'b0);
        chk_out("rst_stall_outputs", '0);
        chk_bit("rst_stall_ready", ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        idle(3);
        chk_int("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
